dm_port_arbiter: RTL and testbench

Shares the single-port data memory between two requesters: the CPU MEM stage (port C) and the DMA/loader engine (port D). CPU has fixed priority, bounded by a starvation limit. DMA may hold the memory for locked bursts, bounded by a maximum burst length. Sits between the pipeline/DMA and the data memory array, which has combinational read and writes on the posedge with byte enables.

---
 rtl/dm_port_arbiter_pkg.sv | 32 +++
 rtl/dm_port_arbiter_if.sv | 55 +++++
 rtl/dm_req_check.sv | 32 +++
 rtl/dm_port_arbiter.sv | 109 ++++++++++
 tb/tb_dm_port_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dm_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter_pkg
// Brief    : Shared arbiter state encoding and legal byte-enable patterns.
// Revision : 1.0 - initial release
// ============================================================================
package dm_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_DBURST = 1'b1
  } arbState_t;

  // Byte-lane patterns also used by the MEM-stage byte-lane formatter.
  localparam logic [3:0] c_beWord   = 4'b1111;
  localparam logic [3:0] c_beHalfLo = 4'b0011;
  localparam logic [3:0] c_beHalfHi = 4'b1100;
  localparam logic [3:0] c_beByte0  = 4'b0001;
  localparam logic [3:0] c_beByte1  = 4'b0010;
  localparam logic [3:0] c_beByte2  = 4'b0100;
  localparam logic [3:0] c_beByte3  = 4'b1000;

  function automatic logic isLegalBe(input logic [3:0] be);
    case (be)
      c_beWord, c_beHalfLo, c_beHalfHi,
      c_beByte0, c_beByte1, c_beByte2, c_beByte3: isLegalBe = 1'b1;
      default:                                    isLegalBe = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter_if
// Brief    : CPU, DMA and data-memory signal bundle around the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_port_arbiter_if #(
  parameter int AW = 12
);
  logic          c_req;
  logic          c_we;
  logic [3:0]    c_be;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic          c_ack;
  logic          c_err;
  logic [31:0]   c_rdata;
  logic          cpu_stall;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_lock;
  logic          d_ack;
  logic          d_err;
  logic [31:0]   d_rdata;

  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [3:0]    m_be;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  c_req, c_we, c_be, c_addr, c_wdata,
    output c_ack, c_err, c_rdata, cpu_stall,
    input  d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    output d_ack, d_err, d_rdata,
    output m_addr, m_we, m_be, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_be, c_addr, c_wdata,
    input  c_ack, c_err, c_rdata, cpu_stall,
    output d_req, d_we, d_be, d_addr, d_wdata, d_lock,
    input  d_ack, d_err, d_rdata,
    input  m_addr, m_we, m_be, m_wdata,
    output m_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dm_req_check.sv
`default_nettype none
// ============================================================================
// Module   : dm_req_check
// Brief    : Combinational fault detection for one data-memory request.
// Revision : 1.0 - initial release
// ============================================================================
module dm_req_check
  import dm_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  output logic        fault
);

  // One extra bit so DEPTH*4 never wraps for the largest memories.
  localparam logic [32:0] c_byteLimit = 33'(DEPTH) << 2;

  logic w_misaligned;
  logic w_outOfRange;
  logic w_badBe;

  always_comb begin
    w_misaligned = (addr[1:0] != 2'b00);
    w_outOfRange = ({1'b0, addr} >= c_byteLimit);
    w_badBe      = (be == 4'b0000) || !isLegalBe(be);
    fault        = w_misaligned || w_outOfRange || w_badBe;
  end

endmodule
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Brief    : CPU/DMA single-port data-memory arbiter with starvation and
//            locked-burst bounds; grants and completes in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dm_port_arbiter
  import dm_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic               clk,
  input  logic               reset,
  dm_port_arbiter_if.slave   bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] c_starveLimit = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] c_maxBurst    = BW'(MAX_BURST);

  arbState_t     r_state;
  logic [SW-1:0] r_starveCnt;
  logic [BW-1:0] r_burstCnt;

  logic          w_burstHold;
  logic          w_starved;
  logic          w_grantC;
  logic          w_grantD;
  logic          w_grant;
  logic          w_selWe;
  logic [3:0]    w_selBe;
  logic [31:0]   w_selAddr;
  logic [31:0]   w_selWdata;
  logic          w_fault;
  logic [BW-1:0] w_burstInc;

  always_comb begin
    w_burstHold = (r_state == ST_DBURST) && bus.d_req && (r_burstCnt < c_maxBurst);
    w_starved   = bus.c_req && bus.d_req && (r_starveCnt == c_starveLimit);
    // No grant at all while reset is held, so nothing is written that cycle.
    w_grantD    = !reset && (w_burstHold || w_starved || (bus.d_req && !bus.c_req));
    w_grantC    = !reset && bus.c_req && !w_grantD;
    w_grant     = w_grantC || w_grantD;
    w_burstInc  = r_burstCnt + 1'b1;

    w_selWe     = w_grantD ? bus.d_we    : bus.c_we;
    w_selBe     = w_grantD ? bus.d_be    : bus.c_be;
    w_selAddr   = w_grantD ? bus.d_addr  : bus.c_addr;
    w_selWdata  = w_grantD ? bus.d_wdata : bus.c_wdata;
  end

  dm_req_check #(
    .DEPTH (DEPTH)
  ) u_reqCheck (
    .addr  (w_selAddr),
    .be    (w_selBe),
    .fault (w_fault)
  );

  always_comb begin
    bus.c_ack     = w_grantC && !w_fault;
    bus.c_err     = w_grantC &&  w_fault;
    bus.d_ack     = w_grantD && !w_fault;
    bus.d_err     = w_grantD &&  w_fault;
    bus.c_rdata   = bus.m_rdata;
    bus.d_rdata   = bus.m_rdata;
    bus.cpu_stall = bus.c_req && !(bus.c_ack || bus.c_err);

    bus.m_addr    = w_selAddr[AW+1:2];
    bus.m_be      = w_selBe;
    bus.m_wdata   = w_selWdata;
    bus.m_we      = w_grant && w_selWe && !w_fault;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_starveCnt <= '0;
      r_burstCnt  <= '0;
    end else begin
      if (w_grantD || !bus.d_req) begin
        r_starveCnt <= '0;
      end else if (w_grantC && (r_starveCnt < c_starveLimit)) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end

      // Reaching MAX_BURST releases ownership so the next cycle uses normal priority.
      if (w_grantD) begin
        if (bus.d_lock && (w_burstInc < c_maxBurst)) begin
          r_state    <= ST_DBURST;
          r_burstCnt <= w_burstInc;
        end else begin
          r_state    <= ST_IDLE;
          r_burstCnt <= '0;
        end
      end else if (r_state == ST_DBURST) begin
        r_state    <= ST_IDLE;
        r_burstCnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Brief    : Directed self-checking bench for dm_port_arbiter with a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem [0:DEPTH-1];

  dm_port_arbiter_if #(.AW(AW)) bus ();

  dm_port_arbiter #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .STARVE_LIMIT (4),
    .MAX_BURST    (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.m_rdata = mem[bus.m_addr];

  always @(posedge clk) begin
    if (bus.m_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.m_be[b]) mem[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic setC(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bus.c_req = req; bus.c_we = we; bus.c_be = be; bus.c_addr = addr; bus.c_wdata = wdata;
  endtask

  task automatic setD(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    bus.d_req = req; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
    bus.d_lock = lock;
  endtask

  // 0 = no grant, 1 = CPU, 2 = DMA
  function automatic logic [31:0] grantCode();
    return {30'd0, bus.d_ack | bus.d_err, bus.c_ack | bus.c_err};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    reset = 1'b1;
    setC(0, 0, 4'h0, 32'h0, 32'h0);
    setD(0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Reset: a CPU write presented during reset must be ignored.
    @(negedge clk);
    setC(1, 1, 4'hF, 32'h10, 32'h11111111);
    #1;
    chk("rst_c_ack", {31'd0, bus.c_ack}, 32'd0);
    chk("rst_m_we", {31'd0, bus.m_we}, 32'd0);
    chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    setC(0, 0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("idle_grant", grantCode(), 32'd0);
    chk("idle_m_we", {31'd0, bus.m_we}, 32'd0);
    @(negedge clk);
    setC(1, 0, 4'hF, 32'h10, 32'h0);
    #1;
    chk("rst_nowrite", bus.c_rdata, 32'h0);
    @(negedge clk);

    // Test 1: CPU word write then read-back.
    setC(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    #1;
    chk("t1_c_ack", {31'd0, bus.c_ack}, 32'd1);
    chk("t1_m_addr", 32'(bus.m_addr), 32'd4);
    chk("t1_m_we", {31'd0, bus.m_we}, 32'd1);
    @(negedge clk);
    setC(1, 0, 4'hF, 32'h10, 32'h0);
    #1;
    chk("t1_rd_ack", {31'd0, bus.c_ack}, 32'd1);
    chk("t1_rdata", bus.c_rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Test 2: continuous contention -> C,C,C,C,D repeating.
    setC(1, 0, 4'hF, 32'h10, 32'h0);
    setD(1, 0, 4'hF, 32'h14, 32'h0, 0);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] expG;
      expG = (i == 4 || i == 9) ? 32'd2 : 32'd1;
      #1;
      chk($sformatf("t2_grant%0d", i), grantCode(), expG);
      chk($sformatf("t2_stall%0d", i), {31'd0, bus.cpu_stall}, (expG == 32'd2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    setC(0, 0, 4'h0, 32'h0, 32'h0);
    setD(0, 0, 4'h0, 32'h0, 32'h0, 0);
    @(negedge clk);

    // Test 3: locked DMA burst bounded at 8, CPU slips in, DMA resumes.
    for (int i = 0; i < 12; i++) begin
      logic [31:0] expG;
      setD(1, 0, 4'hF, 32'h100, 32'h0, 1);
      setC((i >= 1 && i <= 8) ? 1'b1 : 1'b0, 0, 4'hF, 32'h10, 32'h0);
      expG = (i < 8) ? 32'd2 : ((i == 8) ? 32'd1 : 32'd2);
      #1;
      chk($sformatf("t3_grant%0d", i), grantCode(), expG);
      @(negedge clk);
    end
    setC(0, 0, 4'h0, 32'h0, 32'h0);
    setD(0, 0, 4'h0, 32'h0, 32'h0, 0);
    #1;
    chk("t3_release", grantCode(), 32'd0);
    @(negedge clk);

    // Test 4: faulting CPU writes leave memory untouched.
    setC(1, 1, 4'hF, 32'h4000, 32'h12345678);
    #1;
    chk("t4_range_err", {30'd0, bus.c_err, bus.c_ack}, 32'd2);
    chk("t4_range_we", {31'd0, bus.m_we}, 32'd0);
    @(negedge clk);
    setC(1, 1, 4'hF, 32'h12, 32'h12345678);
    #1;
    chk("t4_align_err", {30'd0, bus.c_err, bus.c_ack}, 32'd2);
    chk("t4_align_we", {31'd0, bus.m_we}, 32'd0);
    @(negedge clk);
    setC(1, 1, 4'b0101, 32'h10, 32'h12345678);
    #1;
    chk("t4_be_err", {30'd0, bus.c_err, bus.c_ack}, 32'd2);
    chk("t4_be_we", {31'd0, bus.m_we}, 32'd0);
    @(negedge clk);
    setC(1, 1, 4'b0000, 32'h10, 32'h12345678);
    #1;
    chk("t4_be0_err", {30'd0, bus.c_err, bus.c_ack}, 32'd2);
    @(negedge clk);
    setC(1, 0, 4'hF, 32'h10, 32'h0);
    #1;
    chk("t4_unchanged", bus.c_rdata, 32'hDEADBEEF);
    @(negedge clk);
    setC(1, 0, 4'hF, 32'h3FFC, 32'h0);
    #1;
    chk("t4_top_word", {30'd0, bus.c_err, bus.c_ack}, 32'd1);
    @(negedge clk);
    setC(0, 0, 4'h0, 32'h0, 32'h0);

    // Test 6: DMA byte store into lane 2.
    setD(1, 1, 4'b0100, 32'h20, 32'h00220000, 0);
    #1;
    chk("t6_d_ack", {31'd0, bus.d_ack}, 32'd1);
    chk("t6_m_addr", 32'(bus.m_addr), 32'd8);
    @(negedge clk);
    setD(1, 0, 4'hF, 32'h20, 32'h0, 0);
    #1;
    chk("t6_rdata", bus.d_rdata, 32'h00220000);
    @(negedge clk);

    // Test 5: reset during the third locked beat.
    setD(1, 1, 4'hF, 32'h40, 32'hA1A1A1A1, 1);
    #1;
    chk("t5_beat1", {31'd0, bus.d_ack}, 32'd1);
    @(negedge clk);
    setD(1, 1, 4'hF, 32'h44, 32'hA2A2A2A2, 1);
    #1;
    chk("t5_beat2", {31'd0, bus.d_ack}, 32'd1);
    @(negedge clk);
    setD(1, 1, 4'hF, 32'h48, 32'hA3A3A3A3, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_ack", {31'd0, bus.d_ack}, 32'd0);
    chk("t5_rst_we", {31'd0, bus.m_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    setC(1, 0, 4'hF, 32'h40, 32'h0);
    setD(1, 0, 4'hF, 32'h44, 32'h0, 1);
    #1;
    chk("t5_post_grant", grantCode(), 32'd1);
    chk("t5_beat1_data", bus.c_rdata, 32'hA1A1A1A1);
    @(negedge clk);
    setD(0, 0, 4'h0, 32'h0, 32'h0, 0);
    setC(1, 0, 4'hF, 32'h48, 32'h0);
    #1;
    chk("t5_beat3_data", bus.c_rdata, 32'h0);
    @(negedge clk);
    setC(1, 0, 4'hF, 32'h44, 32'h0);
    #1;
    chk("t5_beat2_data", bus.c_rdata, 32'hA2A2A2A2);
    @(negedge clk);
    setC(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
